// File: rtl/psr_pkg.sv
// Shared definitions for the program status register unit:
// mode encodings, CPSR bit positions, reset value and mode helpers.
package psr_pkg;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  localparam int I_BIT = 7;
  localparam int F_BIT = 6;
  localparam int T_BIT = 5;

  localparam logic [31:0] CPSR_RST  = 32'h0000_00D3;
  // NZCV plus the control byte; everything else reads as zero
  localparam logic [31:0] IMPL_MASK = 32'hF000_00FF;

  function automatic logic mode_valid(input logic [4:0] m);
    return (m == MODE_USR) || (m == MODE_FIQ) || (m == MODE_IRQ) ||
           (m == MODE_SVC) || (m == MODE_ABT) || (m == MODE_UND) ||
           (m == MODE_SYS);
  endfunction

  function automatic logic mode_banked(input logic [4:0] m);
    return (m == MODE_FIQ) || (m == MODE_IRQ) || (m == MODE_SVC) ||
           (m == MODE_ABT) || (m == MODE_UND);
  endfunction

  function automatic logic [2:0] bank_idx(input logic [4:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    case (m)
      MODE_FIQ: idx = 3'd0;
      MODE_IRQ: idx = 3'd1;
      MODE_SVC: idx = 3'd2;
      MODE_ABT: idx = 3'd3;
      MODE_UND: idx = 3'd4;
      default:  idx = 3'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/spsr_bank.sv
// Five banked SPSRs: one byte-masked write port, one read port keyed by mode.
// Writes land the cycle after the write edge; read is combinational, 0 in USR/SYS.
module spsr_bank
  import psr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_idx,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_data,
  input  logic [4:0]  rd_mode,
  output logic [31:0] rd_data
);

  logic [31:0] regs [5];
  logic [31:0] bit_mask;

  assign bit_mask = {{8{wr_be[3]}}, {8{wr_be[2]}}, {8{wr_be[1]}}, {8{wr_be[0]}}} & IMPL_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < 5; i++) begin
        if (wr_idx == 3'(i))
          regs[i] <= (regs[i] & ~bit_mask) | (wr_data & bit_mask);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (mode_banked(rd_mode)) begin
      for (int i = 0; i < 5; i++) begin
        if (bank_idx(rd_mode) == 3'(i)) rd_data = regs[i];
      end
    end
  end

endmodule

// File: rtl/psr_unit.sv
// CPSR plus banked SPSRs: exception entry, restore, MSR and ALU flag updates.
// One-cycle update latency, all outputs registered except spsr (bank read by registered mode).
module psr_unit
  import psr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flag_we,
  input  logic [3:0]  flag_mask,
  input  logic [3:0]  flag_in,
  input  logic        msr_we,
  input  logic        msr_spsr,
  input  logic [3:0]  msr_field,
  input  logic [31:0] msr_data,
  input  logic        restore,
  input  logic        exc_req,
  input  logic [4:0]  exc_mode,
  input  logic        exc_set_f,
  output logic [31:0] cpsr,
  output logic [31:0] spsr,
  output logic        n,
  output logic        z,
  output logic        c,
  output logic        v,
  output logic        thumb,
  output logic        irq_mask,
  output logic        fiq_mask,
  output logic [4:0]  mode,
  output logic        priv
);

  logic [31:0] cpsr_q;
  logic [31:0] cpsr_nxt;
  logic [31:0] spsr_cur;
  logic        bank_we;
  logic [2:0]  bank_idx_w;
  logic [3:0]  bank_be;
  logic [31:0] bank_wdata;
  logic        priv_q;

  assign priv_q = (cpsr_q[4:0] != MODE_USR);

  spsr_bank u_spsr_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bank_we),
    .wr_idx  (bank_idx_w),
    .wr_be   (bank_be),
    .wr_data (bank_wdata),
    .rd_mode (cpsr_q[4:0]),
    .rd_data (spsr_cur)
  );

  // Only the highest-priority request is considered; a rejected one still blocks lower ones.
  always_comb begin
    cpsr_nxt   = cpsr_q;
    bank_we    = 1'b0;
    bank_idx_w = 3'd0;
    bank_be    = 4'b0000;
    bank_wdata = cpsr_q;
    if (en) begin
      if (exc_req) begin
        if (mode_banked(exc_mode)) begin
          bank_we           = 1'b1;
          bank_idx_w        = bank_idx(exc_mode);
          bank_be           = 4'b1111;
          bank_wdata        = cpsr_q;
          cpsr_nxt[4:0]     = exc_mode;
          cpsr_nxt[I_BIT]   = 1'b1;
          cpsr_nxt[F_BIT]   = cpsr_q[F_BIT] | exc_set_f;
          cpsr_nxt[T_BIT]   = 1'b0;
        end
      end else if (restore) begin
        if (mode_banked(cpsr_q[4:0])) begin
          cpsr_nxt = spsr_cur & IMPL_MASK;
          if (!mode_valid(spsr_cur[4:0])) cpsr_nxt[4:0] = cpsr_q[4:0];
        end
      end else if (msr_we) begin
        if (!msr_spsr) begin
          if (msr_field[3]) cpsr_nxt[31:28] = msr_data[31:28];
          if (msr_field[0] && priv_q && mode_valid(msr_data[4:0])) begin
            cpsr_nxt[I_BIT] = msr_data[I_BIT];
            cpsr_nxt[F_BIT] = msr_data[F_BIT];
            cpsr_nxt[4:0]   = msr_data[4:0];
          end
        end else if (mode_banked(cpsr_q[4:0])) begin
          bank_we    = 1'b1;
          bank_idx_w = bank_idx(cpsr_q[4:0]);
          bank_be    = {msr_field[3], 2'b00, msr_field[0]};
          bank_wdata = msr_data;
        end
      end else if (flag_we) begin
        for (int i = 0; i < 4; i++) begin
          if (flag_mask[i]) cpsr_nxt[28+i] = flag_in[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cpsr_q <= CPSR_RST;
    else     cpsr_q <= cpsr_nxt & IMPL_MASK;
  end

  assign cpsr     = cpsr_q;
  assign spsr     = spsr_cur;
  assign n        = cpsr_q[31];
  assign z        = cpsr_q[30];
  assign c        = cpsr_q[29];
  assign v        = cpsr_q[28];
  assign thumb    = cpsr_q[T_BIT];
  assign irq_mask = cpsr_q[I_BIT];
  assign fiq_mask = cpsr_q[F_BIT];
  assign mode     = cpsr_q[4:0];
  assign priv     = priv_q;

endmodule
